// File: rtl/ping_pong_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ping_pong_sequencer
// Description : Profile FIFO plus sequencer that programs and steps a
//               ping-pong counter through {max,min,bounces} profiles.
// Revision    : 1.0 - initial release
// ============================================================================
module ping_pong_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int BCNT_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_max,
  input  logic [WIDTH-1:0]  cfg_min,
  input  logic [BCNT_W-1:0] cfg_bounces,
  input  logic              start,
  input  logic              pause,
  input  logic              flip_req,
  input  logic              cnt_direction,
  input  logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_enable,
  output logic              cnt_flip,
  output logic [WIDTH-1:0]  cnt_max,
  output logic [WIDTH-1:0]  cnt_min,
  output logic              busy,
  output logic              done,
  output logic              err_invalid,
  output logic              err_timeout
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam int ENTRY_W = 2 * WIDTH + BCNT_W;

  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(DEPTH);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_PAUSED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic                ready_q, ready_d;
  logic [WIDTH-1:0]    cnt_max_q, cnt_max_d;
  logic [WIDTH-1:0]    cnt_min_q, cnt_min_d;
  logic [BCNT_W-1:0]   target_q, target_d;
  logic [BCNT_W-1:0]   bounce_cnt_q, bounce_cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                prev_dir_q, prev_dir_d;
  logic                flip_mask_q, flip_mask_d;
  logic                cnt_enable_q, cnt_enable_d;
  logic                cnt_flip_q, cnt_flip_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_invalid_q, err_invalid_d;
  logic                err_timeout_q, err_timeout_d;

  logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
  logic [ENTRY_W-1:0]  head;
  logic [WIDTH-1:0]    head_max;
  logic [WIDTH-1:0]    head_min;
  logic [BCNT_W-1:0]   head_bnc;
  logic [PTR_W:0]      fill;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push_try;
  logic                cfg_bad;
  logic                push;
  logic                bounce;
  logic                advance;
  logic                unused_cnt_out;

  // Sequencing is driven purely by direction changes; the count value is not needed.
  assign unused_cnt_out = ^cnt_out;

  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == DEPTH_C);
  assign pop        = (state_q == ST_LOAD);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
  assign cfg_ready  = ready_q && (!fifo_full || pop);
  assign push_try   = cfg_valid && cfg_ready;
  assign cfg_bad    = (cfg_max <= cfg_min);
  assign push       = push_try && !cfg_bad;

  assign head     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign head_max = head[ENTRY_W-1 -: WIDTH];
  assign head_min = head[BCNT_W +: WIDTH];
  assign head_bnc = head[BCNT_W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {cfg_max, cfg_min, cfg_bounces};
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ready_d       = 1'b1;
    cnt_max_d     = cnt_max_q;
    cnt_min_d     = cnt_min_q;
    target_d      = target_q;
    bounce_cnt_d  = bounce_cnt_q;
    timer_d       = timer_q;
    prev_dir_d    = cnt_direction;
    flip_mask_d   = cnt_flip_q;
    cnt_flip_d    = flip_req && (state_q == ST_RUN) && !pause;
    done_d        = 1'b0;
    err_invalid_d = push_try && cfg_bad;
    err_timeout_d = err_timeout_q;
    advance       = 1'b0;
    // The direction change that follows a forwarded flip is not an end-point bounce.
    bounce        = (cnt_direction != prev_dir_q) && !flip_mask_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_timeout_d = 1'b0;
          if (fifo_empty) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        cnt_max_d    = head_max;
        cnt_min_d    = head_min;
        target_d     = (head_bnc == '0) ? BCNT_ONE : head_bnc;
        bounce_cnt_d = '0;
        timer_d      = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_PAUSED: begin
        // Bounces still land in PAUSED: the counter moved on the last enabled edge.
        if (bounce) begin
          bounce_cnt_d = bounce_cnt_q + BCNT_ONE;
          timer_d      = '0;
          advance      = (bounce_cnt_d == target_q);
        end else if (state_q == ST_RUN) begin
          timer_d = timer_q + TMR_ONE;
          if (timer_d == TMR_LIMIT) begin
            err_timeout_d = 1'b1;
            advance       = 1'b1;
          end
        end
        if (advance) begin
          if (fifo_empty) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = pause ? ST_PAUSED : ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cnt_enable_d = (state_d == ST_RUN);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ready_q       <= 1'b0;
      cnt_max_q     <= '0;
      cnt_min_q     <= '0;
      target_q      <= '0;
      bounce_cnt_q  <= '0;
      timer_q       <= '0;
      prev_dir_q    <= 1'b0;
      flip_mask_q   <= 1'b0;
      cnt_enable_q  <= 1'b0;
      cnt_flip_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_invalid_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ready_q       <= ready_d;
      cnt_max_q     <= cnt_max_d;
      cnt_min_q     <= cnt_min_d;
      target_q      <= target_d;
      bounce_cnt_q  <= bounce_cnt_d;
      timer_q       <= timer_d;
      prev_dir_q    <= prev_dir_d;
      flip_mask_q   <= flip_mask_d;
      cnt_enable_q  <= cnt_enable_d;
      cnt_flip_q    <= cnt_flip_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_invalid_q <= err_invalid_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cnt_enable  = cnt_enable_q;
  assign cnt_flip    = cnt_flip_q;
  assign cnt_max     = cnt_max_q;
  assign cnt_min     = cnt_min_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_invalid = err_invalid_q;
  assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ping_pong_sequencer
// Description : Closed-loop bench: a ping-pong counter model plus a profile-level
//               reference of the sequencer, compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ping_pong_sequencer;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int BCNT_W  = 8;
  localparam int TIMEOUT = 64;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_SETTLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_HELD   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [WIDTH-1:0]  cfg_max = '0;
  logic [WIDTH-1:0]  cfg_min = '0;
  logic [BCNT_W-1:0] cfg_bounces = '0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              flip_req = 1'b0;
  logic              cnt_direction = 1'b1;
  logic [WIDTH-1:0]  cnt_out = '0;
  logic              cnt_enable;
  logic              cnt_flip;
  logic [WIDTH-1:0]  cnt_max;
  logic [WIDTH-1:0]  cnt_min;
  logic              busy;
  logic              done;
  logic              err_invalid;
  logic              err_timeout;

  always #5 clk = ~clk;

  ping_pong_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BCNT_W(BCNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_max(cfg_max), .cfg_min(cfg_min), .cfg_bounces(cfg_bounces),
    .start(start), .pause(pause), .flip_req(flip_req),
    .cnt_direction(cnt_direction), .cnt_out(cnt_out),
    .cnt_enable(cnt_enable), .cnt_flip(cnt_flip), .cnt_max(cnt_max),
    .cnt_min(cnt_min), .busy(busy), .done(done),
    .err_invalid(err_invalid), .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: profile queue, bounces left, quiet RUN cycles since last bounce.
  typedef struct { int hi; int lo; int left; } prof_t;
  prof_t q[$];
  int    phase, left, quiet;
  bit    m_init, last_dir, flip_echo;
  bit    e_en, e_flip, e_busy, e_done, e_inv, e_tmo;
  int    e_max, e_min;

  // Counter model and the DUT outputs it saw during the current cycle.
  bit c_dir = 1'b1;
  int c_val = 0;
  bit stuck = 1'b0;
  bit s_en = 1'b0, s_flip = 1'b0;
  int s_max = 0, s_min = 0;

  int n_done_seen = 0;
  int mm_log[$];
  int last_mm = 0;

  task automatic model_reset();
    q.delete();
    phase = P_IDLE; left = 0; quiet = 0;
    m_init = 0; last_dir = 0; flip_echo = 0;
    e_en = 0; e_flip = 0; e_busy = 0; e_done = 0; e_inv = 0; e_tmo = 0;
    e_max = 0; e_min = 0;
  endtask

  task automatic model_step();
    bit    can_push, bad, accept, moved, finish;
    int    nxt;
    prof_t p;
    can_push = m_init && (q.size() < DEPTH || phase == P_LOAD);
    bad      = (cfg_max <= cfg_min);
    accept   = cfg_valid && can_push && !bad;
    e_inv    = cfg_valid && can_push && bad;
    e_done   = 0;
    moved    = (cnt_direction != last_dir) && !flip_echo;
    flip_echo = e_flip;
    e_flip   = flip_req && (phase == P_RUN) && !pause;
    last_dir = cnt_direction;
    nxt      = phase;
    finish   = 0;
    case (phase)
      P_IDLE: if (start) begin
        e_tmo = 0;
        if (q.size() == 0) e_done = 1; else nxt = P_LOAD;
      end
      P_LOAD: begin
        p = q.pop_front();
        e_max = p.hi; e_min = p.lo; left = p.left; quiet = 0;
        nxt = P_SETTLE;
      end
      P_SETTLE: if (!pause) nxt = P_RUN;
      default: begin
        if (moved) begin
          left--; quiet = 0;
          finish = (left == 0);
        end else if (phase == P_RUN) begin
          quiet++;
          if (quiet == TIMEOUT) begin e_tmo = 1; finish = 1; end
        end
        if (finish) begin
          if (q.size() == 0) begin nxt = P_IDLE; e_done = 1; end
          else nxt = P_LOAD;
        end else begin
          nxt = pause ? P_HELD : P_RUN;
        end
      end
    endcase
    if (accept) begin
      p.hi = int'(cfg_max); p.lo = int'(cfg_min);
      p.left = (cfg_bounces == 0) ? 1 : int'(cfg_bounces);
      q.push_back(p);
    end
    phase  = nxt;
    e_en   = (phase == P_RUN);
    e_busy = (phase != P_IDLE);
    m_init = 1;
  endtask

  task automatic counter_step();
    bit nd;
    if (stuck || !s_en) return;
    nd = c_dir;
    if (s_flip) nd = !c_dir;
    else if (c_dir && c_val >= s_max) nd = 1'b0;
    else if (!c_dir && c_val <= s_min) nd = 1'b1;
    c_dir = nd;
    if (nd && c_val < s_max) c_val++;
    else if (!nd && c_val > s_min) c_val--;
  endtask

  task automatic check_outputs();
    bit e_ready;
    e_ready = m_init && (q.size() < DEPTH || phase == P_LOAD);
    check_eq("cfg_ready",   32'(cfg_ready),   32'(e_ready));
    check_eq("cnt_enable",  32'(cnt_enable),  32'(e_en));
    check_eq("cnt_flip",    32'(cnt_flip),    32'(e_flip));
    check_eq("cnt_max",     32'(cnt_max),     32'(e_max));
    check_eq("cnt_min",     32'(cnt_min),     32'(e_min));
    check_eq("busy",        32'(busy),        32'(e_busy));
    check_eq("done",        32'(done),        32'(e_done));
    check_eq("err_invalid", 32'(err_invalid), 32'(e_inv));
    check_eq("err_timeout", 32'(err_timeout), 32'(e_tmo));
  endtask

  task automatic cycle();
    int mm;
    @(posedge clk);
    model_step();
    #1;
    counter_step();
    cnt_direction = c_dir;
    cnt_out       = WIDTH'(c_val);
    @(negedge clk);
    check_outputs();
    s_en = cnt_enable; s_flip = cnt_flip;
    s_max = int'(cnt_max); s_min = int'(cnt_min);
    if (done === 1'b1) n_done_seen++;
    mm = int'({cnt_max, cnt_min});
    if (mm != last_mm) begin mm_log.push_back(mm); last_mm = mm; end
  endtask

  task automatic push(input int hi, input int lo, input int bn);
    cfg_valid = 1'b1;
    cfg_max = WIDTH'(hi); cfg_min = WIDTH'(lo); cfg_bounces = BCNT_W'(bn);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int limit);
    int k = 0;
    while ((busy === 1'b1 || e_busy) && k < limit) begin
      cycle();
      k++;
    end
    if (k >= limit) check_eq("idle_wait", 32'({busy, e_busy}), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cycle();
    check_eq("ready_after_rst", 32'(cfg_ready), 32'd1);

    // Single profile, two bounces.
    d0 = n_done_seen;
    push(8, 0, 2);
    pulse_start();
    run_until_idle(200);
    check_eq("single_done_cnt", 32'(n_done_seen - d0), 32'd1);

    // Three profiles applied in order.
    push(4, 0, 1); push(15, 0, 1); push(14, 12, 1);
    d0 = n_done_seen;
    mm_log.delete();
    pulse_start();
    run_until_idle(400);
    check_eq("seq_done_cnt", 32'(n_done_seen - d0), 32'd1);
    check_eq("seq_len", 32'(mm_log.size()), 32'd3);
    if (mm_log.size() == 3) begin
      check_eq("seq_0", 32'(mm_log[0]), 32'h40);
      check_eq("seq_1", 32'(mm_log[1]), 32'hF0);
      check_eq("seq_2", 32'(mm_log[2]), 32'hEC);
    end

    // Illegal profile is rejected; start with nothing queued only pulses done.
    push(1, 4, 3);
    check_eq("invalid_pulse", 32'(err_invalid), 32'd1);
    pulse_start();
    check_eq("empty_start_done", 32'(done), 32'd1);
    check_eq("empty_start_busy", 32'(busy), 32'd0);

    // Manual flip mid-count, then an 8-cycle pause.
    push(4, 0, 4);
    pulse_start();
    repeat (6) cycle();
    flip_req = 1'b1; cycle(); flip_req = 1'b0;
    repeat (3) cycle();
    pause = 1'b1; repeat (8) cycle(); pause = 1'b0;
    run_until_idle(300);

    // Stuck counter times the profile out.
    stuck = 1'b1; c_val = 8;
    push(14, 12, 1);
    pulse_start();
    run_until_idle(200);
    check_eq("timeout_flag", 32'(err_timeout), 32'd1);
    stuck = 1'b0;

    // Fill the FIFO; the fifth push is refused.
    push(3, 0, 1); push(5, 1, 1); push(6, 2, 1); push(2, 0, 1);
    check_eq("full_ready", 32'(cfg_ready), 32'd0);
    push(9, 1, 1);
    d0 = n_done_seen;
    pulse_start();
    run_until_idle(600);
    check_eq("full_done_cnt", 32'(n_done_seen - d0), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_min   = WIDTH'($urandom_range(0, 10));
      if ($urandom_range(0, 7) == 0) cfg_max = WIDTH'($urandom_range(0, 15));
      else cfg_max = WIDTH'($urandom_range(int'(cfg_min) + 1, 15));
      cfg_bounces = BCNT_W'($urandom_range(0, 3));
      start    = ($urandom_range(0, 15) == 0);
      flip_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) pause = !pause;
      cycle();
    end
    cfg_valid = 1'b0; start = 1'b0; flip_req = 1'b0; pause = 1'b0;
    run_until_idle(1000);

    // Asynchronous reset in the middle of a run.
    push(15, 0, 5); push(6, 1, 1);
    pulse_start();
    repeat (6) cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_en = 1'b0; s_flip = 1'b0; s_max = 0; s_min = 0;
    cycle();
    pulse_start();
    check_eq("post_rst_done", 32'(done), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
